// File: rtl/liteic_axil_sram_pkg.sv
// Shared types and constants for the AXI-lite SRAM endpoint.
package liteic_axil_sram_pkg;

   localparam int LINK_ADDR_W = 20;
   localparam int QOS_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_DATA = 2'd1,
      ST_RD_RESP = 2'd2,
      ST_WR_RESP = 2'd3
   } state_e;

   localparam logic RESP_OKAY = 1'b0;
   localparam logic RESP_ERR  = 1'b1;

   typedef struct packed {
      logic [LINK_ADDR_W-1:0] addr;
      logic [QOS_W-1:0]       qos;
   } req_t;

endpackage

// File: rtl/liteic_sp_ram.sv
// Single-port synchronous RAM, per-byte write enables, one-cycle read latency, no reset.
module liteic_sp_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024
) (
   input  logic                        clk_i,
   input  logic                        en,
   input  logic [DATA_WIDTH/8-1:0]     we,
   input  logic [$clog2(DEPTH)-1:0]    addr,
   input  logic [DATA_WIDTH-1:0]       wdata,
   output logic [DATA_WIDTH-1:0]       rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Read returns the pre-write word when a write hits the same address.
   always_ff @(posedge clk_i) begin
      if (en) begin
         for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/liteic_axil_sram_sp.sv
// AXI-lite subordinate serving one link from an internal single-port byte-writable SRAM.
// Define LITEIC_AXIL_SRAM_QOS_ARB_EN to let buffered qos decide read/write conflicts.
module liteic_axil_sram_sp
   import liteic_axil_sram_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int RESP_WIDTH = 1,
   parameter int DEPTH      = 1024,
   localparam int STRB_WIDTH = DATA_WIDTH/8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [ADDR_WIDTH-13:0]  s_axil_ar_addr,
   input  logic [QOS_W-1:0]        s_axil_ar_qos,
   input  logic                    s_axil_ar_valid,
   output logic                    s_axil_ar_ready,
   input  logic [ADDR_WIDTH-13:0]  s_axil_aw_addr,
   input  logic [QOS_W-1:0]        s_axil_aw_qos,
   input  logic                    s_axil_aw_valid,
   output logic                    s_axil_aw_ready,
   input  logic [DATA_WIDTH-1:0]   s_axil_w_data,
   input  logic [STRB_WIDTH-1:0]   s_axil_w_strb,
   input  logic                    s_axil_w_valid,
   output logic                    s_axil_w_ready,
   output logic [DATA_WIDTH-1:0]   s_axil_r_data,
   output logic [RESP_WIDTH-1:0]   s_axil_r_resp,
   output logic                    s_axil_r_valid,
   input  logic                    s_axil_r_ready,
   output logic [RESP_WIDTH-1:0]   s_axil_b_resp,
   output logic                    s_axil_b_valid,
   input  logic                    s_axil_b_ready
);

   localparam int OFS    = $clog2(STRB_WIDTH);
   localparam int RAM_AW = $clog2(DEPTH);

   function automatic logic in_range(input logic [LINK_ADDR_W-1:0] addr);
      logic [31:0] idx;
      idx = 32'(addr >> OFS);
      return idx < 32'(DEPTH);
   endfunction

   function automatic logic [RAM_AW-1:0] ram_idx(input logic [LINK_ADDR_W-1:0] addr);
      return addr[OFS +: RAM_AW];
   endfunction

   state_e                 state_q, state_nxt;
   req_t                   ar_buf, aw_buf;
   logic [DATA_WIDTH-1:0]  w_data_q;
   logic [STRB_WIDTH-1:0]  w_strb_q;
   logic                   ar_full, aw_full, w_full;
   logic                   ar_full_nxt, aw_full_nxt, w_full_nxt;
   logic                   rd_cand, wr_cand, rd_wins, rd_gnt, wr_gnt;
   logic                   last_wr, rd_ok_p1;
   logic                   ram_en;
   logic [STRB_WIDTH-1:0]  ram_we;
   logic [RAM_AW-1:0]      ram_addr;
   logic [DATA_WIDTH-1:0]  ram_rdata;
   logic                   unused_bits;

   always_comb begin
      rd_cand = ar_full;
      wr_cand = aw_full & w_full;
`ifdef LITEIC_AXIL_SRAM_QOS_ARB_EN
      if (ar_buf.qos != aw_buf.qos) rd_wins = ar_buf.qos > aw_buf.qos;
      else                          rd_wins = last_wr;
`else
      rd_wins = last_wr;
`endif
      rd_gnt = (state_q == ST_IDLE) & rd_cand & (~wr_cand | rd_wins);
      wr_gnt = (state_q == ST_IDLE) & wr_cand & ~rd_gnt;

      state_nxt = state_q;
      case (state_q)
         ST_IDLE: begin
            if (rd_gnt)      state_nxt = ST_RD_DATA;
            else if (wr_gnt) state_nxt = ST_WR_RESP;
         end
         ST_RD_DATA: state_nxt = ST_RD_RESP;
         ST_RD_RESP: if (s_axil_r_ready) state_nxt = ST_IDLE;
         ST_WR_RESP: if (s_axil_b_ready) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Buffers free on grant; a full buffer keeps its ready low so capture and grant never collide.
   assign ar_full_nxt = (ar_full & ~rd_gnt) | (s_axil_ar_valid & s_axil_ar_ready);
   assign aw_full_nxt = (aw_full & ~wr_gnt) | (s_axil_aw_valid & s_axil_aw_ready);
   assign w_full_nxt  = (w_full  & ~wr_gnt) | (s_axil_w_valid  & s_axil_w_ready);

   assign ram_en   = rd_gnt | wr_gnt;
   assign ram_addr = rd_gnt ? ram_idx(ar_buf.addr) : ram_idx(aw_buf.addr);
   assign ram_we   = (wr_gnt && in_range(aw_buf.addr)) ? w_strb_q : '0;

   liteic_sp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk_i (clk_i),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (w_data_q),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= ST_IDLE;
         ar_full         <= 1'b0;
         aw_full         <= 1'b0;
         w_full          <= 1'b0;
         s_axil_ar_ready <= 1'b0;
         s_axil_aw_ready <= 1'b0;
         s_axil_w_ready  <= 1'b0;
         s_axil_r_valid  <= 1'b0;
         s_axil_b_valid  <= 1'b0;
         s_axil_r_data   <= '0;
         s_axil_r_resp   <= '0;
         s_axil_b_resp   <= '0;
         last_wr         <= 1'b1;
      end else begin
         state_q         <= state_nxt;
         ar_full         <= ar_full_nxt;
         aw_full         <= aw_full_nxt;
         w_full          <= w_full_nxt;
         s_axil_ar_ready <= ~ar_full_nxt;
         s_axil_aw_ready <= ~aw_full_nxt;
         s_axil_w_ready  <= ~w_full_nxt;
         s_axil_r_valid  <= (state_nxt == ST_RD_RESP);
         s_axil_b_valid  <= (state_nxt == ST_WR_RESP);
         if (ram_en & rd_cand & wr_cand) last_wr <= wr_gnt;
         if (state_q == ST_RD_DATA) begin
            s_axil_r_data <= rd_ok_p1 ? ram_rdata : '0;
            s_axil_r_resp <= rd_ok_p1 ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_ERR);
         end
         if (wr_gnt)
            s_axil_b_resp <= in_range(aw_buf.addr) ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_ERR);
      end
   end

   // Request payloads and the read range flag carry no reset.
   always_ff @(posedge clk_i) begin
      if (s_axil_ar_valid & s_axil_ar_ready) begin
         ar_buf.addr <= s_axil_ar_addr;
`ifdef LITEIC_AXIL_SRAM_QOS_ARB_EN
         ar_buf.qos  <= s_axil_ar_qos;
`else
         ar_buf.qos  <= '0;
`endif
      end
      if (s_axil_aw_valid & s_axil_aw_ready) begin
         aw_buf.addr <= s_axil_aw_addr;
`ifdef LITEIC_AXIL_SRAM_QOS_ARB_EN
         aw_buf.qos  <= s_axil_aw_qos;
`else
         aw_buf.qos  <= '0;
`endif
      end
      if (s_axil_w_valid & s_axil_w_ready) begin
         w_data_q <= s_axil_w_data;
         w_strb_q <= s_axil_w_strb;
      end
      if (rd_gnt) rd_ok_p1 <= in_range(ar_buf.addr);
   end

`ifdef LITEIC_AXIL_SRAM_QOS_ARB_EN
   assign unused_bits = 1'b0;
`else
   assign unused_bits = ^{s_axil_ar_qos, s_axil_aw_qos, ar_buf.qos, aw_buf.qos};
`endif

endmodule

// File: doc/liteic_axil_sram_sp.md
# liteic_axil_sram_sp

AXI-lite subordinate endpoint that terminates one `axi_lite_if_20bit_addr` link and serves it from an internal single-port, byte-writable synchronous RAM.

- Sits at an interconnect output port as the responder for the `sp` modport; the initiator side drives `mp`.
- Buffers one AR and one AW/W request, arbitrates them onto the single RAM port, and returns R/B responses.
- Flags out-of-range addresses with an error response.

## Interface
- ADDR_WIDTH, 32, nominal address width; the link carries ADDR_WIDTH-12 (20) address bits.
- DATA_WIDTH, 32, data width; legal values are 32 or 64. STRB_WIDTH = DATA_WIDTH/8.
- RESP_WIDTH, 1, response width; 0 = OKAY, 1 = ERR.
- DEPTH, 1024, RAM words; power of two, at most 2^(ADDR_WIDTH-12-log2(STRB_WIDTH)).
- clk_i  input  1  single clock; all logic is rising-edge.
- rst_i  input  1  reset; synchronous, active-high.
- s_axil  modport sp  -  link of type axi_lite_if_20bit_addr (ADDR_WIDTH, DATA_WIDTH, RESP_WIDTH). Inputs: ar_*/aw_* addr+qos+valid, w_data/w_strb/w_valid, r_ready, b_ready. Outputs: ar_ready, aw_ready, w_ready, r_data, r_resp, r_valid, b_resp, b_valid.

## Operation
**Request buffers**
- AR, AW and W each have a one-entry buffer; AR and AW store addr and qos.
- x_ready is a registered "buffer empty" flag.
- An entry is captured on x_valid & x_ready. The buffer is freed when its request is granted.

**Address decode**
- Word index = addr[ADDR_WIDTH-13 : log2(STRB_WIDTH)]; the low bits are ignored.
- The address is in range iff index < DEPTH.

**FSM**: IDLE, RD_DATA, RD_RESP, WR_RESP.
- IDLE
  - Read candidate: AR buffer full.
  - Write candidate: AW and W buffers both full.
  - Grant one candidate per cycle.
  - Read grant: present the RAM read and go to RD_DATA.
  - Write grant: write the RAM with w_strb byte enables if in range (no write if out of range) and go to WR_RESP.
- RD_DATA: register the RAM output into r_data (0 if out of range) and r_resp, then go to RD_RESP.
- RD_RESP: r_valid=1; hold r_data/r_resp stable until r_ready, then go to IDLE.
- WR_RESP: b_valid=1 with b_resp; hold until b_ready, then go to IDLE.

**Arbitration**
- When both candidates are present, use the policy in Configuration.
- A last_grant flag supports round-robin. It resets to "write" so that read wins the first tie.

**Buffering during responses**: new AR/AW/W are accepted into empty buffers while a response is pending, but they are not granted until the FSM returns to IDLE.

**Reset**
- Asserting rst_i in any state returns the FSM to IDLE on the next edge and empties all buffers.
- RAM contents are not reset.

## Timing
- Reset values: ar_ready, aw_ready, w_ready, r_valid, b_valid = 0; r_data = 0; r_resp = 0; b_resp = 0.
- Readies rise in the first cycle after rst_i deasserts.
- Read latency: AR handshake at edge of cycle 0 → grant in cycle 1 → RD_DATA in cycle 2 → r_valid in cycle 3.
- Write latency: the later of the AW/W handshakes at edge of cycle 0 → grant and RAM write in cycle 1 → b_valid in cycle 2.
- ar_ready drops in the cycle after its handshake and returns in the cycle after its grant. AW and W behave the same way.
- No combinational path from any input to any output.
- Throughput: one transaction every 3 cycles with responses taken immediately. A read occupies IDLE, RD_DATA, RD_RESP; a write occupies IDLE, WR_RESP.

## Configuration
- LITEIC_AXIL_SRAM_QOS_ARB_EN defined:
  - on an IDLE conflict, the candidate with the higher buffered qos wins;
  - equal qos falls back to round-robin.
- Undefined: qos is ignored (not stored) and conflicts use pure round-robin.

## Structure
- Package liteic_axil_sram_pkg:
  - FSM state enum;
  - RESP_OKAY = 1'b0 and RESP_ERR = 1'b1;
  - a typedef for the buffered request (addr, qos).
- One sub-module, liteic_sp_ram: single-port synchronous RAM with DEPTH × DATA_WIDTH words, per-byte write enable and one-cycle read latency. It has no reset.

## Test plan
- Write 0xDEADBEEF to 0x00010 with strb 0xF, then read 0x00010 → b_valid 2 cycles after the W handshake with b_resp 0; r_valid 3 cycles after AR with r_data 0xDEADBEEF and r_resp 0.
- Write 0x11223344 to 0x00020, then 0x0000AB00 with strb 0b0010; read back → r_data 0x1122AB44.
- DEPTH=1024: write to 0x01000 → b_resp 1. Read 0x01000 → r_data 0, r_resp 1. Reading 0x00000 afterwards still returns its prior value.
- AR, AW and W presented in the same cycle right after reset with qos ar=2, aw=5:
  - macro defined → B completes before R;
  - macro undefined, or qos equal → R first, then B;
  - a second tie → write wins.
- Hold r_ready=0 for 5 cycles in RD_RESP → r_valid and r_data stay stable. A new AR is accepted (ar_ready falls) but produces no grant until r_ready is taken.
- Assert rst_i for 1 cycle during RD_RESP with r_ready low → next cycle r_valid=0 and all readies 0; one cycle after release the readies are 1 and no stale R beat appears.
